// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main controller: state codes,
// opcode/funct values, datapath select codes and the control-vector type.
`timescale 1ns/1ps
package mips_multicycle_control_pkg;

  // State encodings (14 and 15 are unreachable)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JAL     = 4'd12;
  localparam logic [3:0] S_JR      = 4'd13;

  // Opcodes and funct
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // RegDst selects
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  // MemtoReg selects
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // PCSrc selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // Moore control vector decoded from the state register
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_decode.sv
// State-to-control-vector table. Purely combinational; any field not set
// for a state stays 0.
`timescale 1ns/1ps
module mips_multicycle_control_decode
  import mips_multicycle_control_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  // Moore output table indexed by state
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.reg_dst    = REGDST_RT;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so it is the link value
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_R31;
        ctrl.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_REGA;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
//
// state   | meaning
// FETCH   | read instruction into IR, PC <= PC+4
// DECODE  | register read, branch target into ALUOut, dispatch on opcode
// MEMADR  | compute load/store address
// MEMRD   | read data memory into MDR
// MEMWB   | write MDR to rt
// MEMWR   | write reg B to data memory
// EXECUTE | R-type ALU operation
// ALUWB   | write ALUOut to rd
// BRANCH  | compare A/B, conditionally load PC from ALUOut
// ADDIEX  | A + sign-extended immediate
// ADDIWB  | write ALUOut to rt
// JUMP    | PC <= jump target
// JAL     | PC <= jump target, r31 <= PC
// JR      | PC <= reg A
`timescale 1ns/1ps
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic       illegal;
  logic       taken;
  ctrl_t      ctrl;

  mips_multicycle_control_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_FETCH;
    else       state_q <= next_state;
  end

  // Next-state and illegal-opcode detection
  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       next_state = (funct == FUNCT_JR) ? S_JR : S_EXECUTE;
          OP_LW, OP_SW:   next_state = S_MEMADR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI:        next_state = S_ADDIEX;
          OP_J:           next_state = S_JUMP;
          OP_JAL:         next_state = S_JAL;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR:  next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state = S_MEMWB;
      S_EXECUTE: next_state = S_ALUWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
      S_ADDIWB, S_JUMP, S_JAL, S_JR: next_state = S_FETCH;
      default: begin
        next_state = S_FETCH;
        illegal    = 1'b1;
      end
    endcase
  end

  // BNE branches on inequality, BEQ on equality
  assign taken = (opcode == OP_BNE) ? ~zero : zero;

  // Write enables are held off while reset is asserted
  assign IRWrite    = rstb & ctrl.ir_write;
  assign PCWrite    = rstb & ctrl.pc_write;
  assign MemWrite   = rstb & ctrl.mem_write;
  assign RegWrite   = rstb & ctrl.reg_write;
  assign PCEn       = rstb & (ctrl.pc_write | (ctrl.branch & taken));
  assign illegal_op = rstb & illegal;

  assign ALUOp    = ctrl.alu_op;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign IorD     = ctrl.iord;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign PCSrc    = ctrl.pc_src;
  assign state    = state_q;

endmodule
